// File: rtl/lsu_pkg.sv
// Shared types and funct3 decoding for the RV32I load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Size comes from the low bits; bit 2 only selects zero extension.
    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory valid/ready bus between the load/store unit and memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, we, addr, wdata, be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata, be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication/byte enables, load extraction
// with sign/zero extension, and legality of the size/offset pair.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_ext,
    output logic        illegal
);
    logic [31:0] shifted;
    logic        unaligned;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wdata     = store_data;
        be        = 4'b1111;
        load_ext  = shifted;
        unaligned = 1'b0;
        case (f3_size(funct3))
            SZ_B: begin
                wdata    = {4{store_data[7:0]}};
                be       = 4'b0001 << addr_lo;
                load_ext = funct3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata     = {2{store_data[15:0]}};
                be        = 4'b0011 << addr_lo;
                load_ext  = funct3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                unaligned = addr_lo[0];
            end
            default: unaligned = |addr_lo;
        endcase
        illegal = !f3_legal(funct3) || unaligned;
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: drives the dmem bus, stalls the pipeline until
// the access completes and registers the extended load result for writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] mem_data,
    output logic        misaligned,
    output logic        bus_err,
    lsu_if.master       dmem
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e    state, state_nxt;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    f3_q;
    logic [3:0]    be_q;
    logic          we_q;
    logic [CW-1:0] cnt;

    logic          access, in_idle, timeout_hit;
    logic [2:0]    al_f3;
    logic [1:0]    al_off;
    logic [31:0]   al_wdata, al_load;
    logic [3:0]    al_be;
    logic          al_illegal;

    assign access      = req_read | req_write;
    assign in_idle     = (state == IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Live inputs are steered while idle; the latched access is used afterwards.
    assign al_f3  = in_idle ? funct3 : f3_q;
    assign al_off = in_idle ? addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_off),
        .store_data (store_data),
        .rdata      (dmem.rsp_rdata),
        .wdata      (al_wdata),
        .be         (al_be),
        .load_ext   (al_load),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (access) state_nxt = al_illegal ? DONE : REQ;
            REQ: begin
                if (dmem.req_ready) state_nxt = we_q ? DONE : WAIT;
                else if (timeout_hit) state_nxt = DONE;
            end
            WAIT: if (dmem.rsp_valid || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            mem_data   <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: if (access) begin
                    if (al_illegal) begin
                        misaligned <= 1'b1;
                        mem_data   <= '0;
                    end else begin
                        addr_q  <= addr;
                        f3_q    <= funct3;
                        we_q    <= req_write;
                        wdata_q <= al_wdata;
                        be_q    <= req_write ? al_be : 4'b1111;
                        cnt     <= '0;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (state == WAIT && dmem.rsp_valid) begin
                        mem_data <= al_load;
                    end else if (timeout_hit && !(state == REQ && dmem.req_ready)) begin
                        bus_err  <= 1'b1;
                        mem_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall          = access && (state != DONE);
    assign dmem.req_valid = (state == REQ);
    assign dmem.we        = we_q;
    assign dmem.addr      = {addr_q[31:2], 2'b00};
    assign dmem.wdata     = wdata_q;
    assign dmem.be        = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses against
// an arithmetic reference model, and reset/timeout sequences.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO_MAIN = 255;

    logic        clk, rst;
    logic        req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, misaligned, bus_err;
    logic [31:0] mem_data;

    logic        r4_read;
    logic [2:0]  r4_f3;
    logic [31:0] r4_addr;
    logic        stall4, mis4, err4;
    logic [31:0] mem4;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_if bus ();
    lsu_if bus4 ();

    load_store_unit #(.TIMEOUT(TO_MAIN)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .mem_data(mem_data), .misaligned(misaligned), .bus_err(bus_err), .dmem(bus)
    );

    load_store_unit #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .req_read(r4_read), .req_write(1'b0),
        .funct3(r4_f3), .addr(r4_addr), .store_data(32'h0), .stall(stall4),
        .mem_data(mem4), .misaligned(mis4), .bus_err(err4), .dmem(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata;
        int          rdy_dly, rsp_dly;
        logic [31:0] exp_mem, exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_mis, exp_err;
    } vec_t;

    typedef struct {
        int          stall_cycles;
        logic        done, req_seen, unstable, mis, err, valid_done, we;
        logic [31:0] addr, wdata, mem;
        logic [3:0]  be;
    } result_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: access size in bytes, 0 for an undefined funct3.
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_illegal(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        return (sz == 0) || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int sz = m_size(f3);
        int off = int'(a % 4);
        longint v, lim;
        v   = longint'(rd) >> (8 * off);
        lim = longint'(1) << (8 * sz);
        v   = v % lim;
        if (f3 < 3'd4 && sz < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (m_size(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        int v;
        if (sz == 4) return 4'hF;
        v = ((1 << sz) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                                input int rdy, input int rsp, input logic [31:0] em,
                                input logic [31:0] ew, input logic [3:0] eb,
                                input logic mis, input logic err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rdata;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_mem = em; v.exp_wdata = ew;
        v.exp_be = eb; v.exp_mis = mis; v.exp_err = err;
        return v;
    endfunction

    // Presents one access, plays the memory side, returns what the DUT showed.
    task automatic run_access(input vec_t v, output result_t r);
        int  req_cycles = 0;
        int  wait_cycles = 0;
        bit  accepted = 0;
        bit  acc_now;
        r.stall_cycles = 0; r.done = 0; r.req_seen = 0; r.unstable = 0;
        r.mis = 0; r.err = 0; r.valid_done = 0; r.we = 0;
        r.addr = '0; r.wdata = '0; r.mem = '0; r.be = '0;
        req_read = v.rd; req_write = v.wr; funct3 = v.f3; addr = v.addr;
        store_data = v.sd; bus.rsp_rdata = v.rdata;
        for (int cyc = 0; cyc < 400 && !r.done; cyc++) begin
            bus.req_ready = (req_cycles >= v.rdy_dly);
            bus.rsp_valid = accepted && (wait_cycles >= v.rsp_dly);
            @(negedge clk);
            if (!stall) begin
                r.done = 1; r.mis = misaligned; r.err = bus_err;
                r.mem = mem_data; r.valid_done = bus.req_valid;
            end else begin
                r.stall_cycles++;
                acc_now = 0;
                if (bus.req_valid) begin
                    if (!r.req_seen) begin
                        r.req_seen = 1; r.addr = bus.addr; r.we = bus.we;
                        r.wdata = bus.wdata; r.be = bus.be;
                    end else if ({bus.addr, bus.we, bus.wdata, bus.be} !== {r.addr, r.we, r.wdata, r.be}) begin
                        r.unstable = 1;
                    end
                    if (bus.req_ready) acc_now = 1;
                    else req_cycles++;
                end
                if (accepted) wait_cycles++;
                if (acc_now) accepted = 1;
            end
            @(posedge clk); #1;
        end
        req_read = 0; req_write = 0; bus.req_ready = 0; bus.rsp_valid = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        result_t r;
        int needed, exp_stall;
        run_access(v, r);
        needed = v.rdy_dly + 1 + (v.wr ? 0 : v.rsp_dly + 1);
        if (v.exp_mis)          exp_stall = 1;
        else if (needed > TO_MAIN) exp_stall = 1 + TO_MAIN;
        else                    exp_stall = 1 + needed;
        check({tag, " completes"}, 32'(r.done), 32'd1);
        check({tag, " stall cycles"}, r.stall_cycles, exp_stall);
        check({tag, " misaligned"}, 32'(r.mis), 32'(v.exp_mis));
        check({tag, " bus_err"}, 32'(r.err), 32'(v.exp_err));
        check({tag, " mem_data"}, r.mem, v.exp_mem);
        check({tag, " req_valid in done"}, 32'(r.valid_done), 32'd0);
        check({tag, " request issued"}, 32'(r.req_seen), 32'(!v.exp_mis));
        if (!v.exp_mis) begin
            check({tag, " dmem_addr"}, r.addr, {v.addr[31:2], 2'b00});
            check({tag, " dmem_we"}, 32'(r.we), 32'(v.wr));
            check({tag, " dmem_be"}, 32'(r.be), 32'(v.exp_be));
            if (v.wr) check({tag, " dmem_wdata"}, r.wdata, v.exp_wdata);
            check({tag, " request stable"}, 32'(r.unstable), 32'd0);
        end
    endtask

    task automatic model_fill(inout vec_t v, inout logic [31:0] mm);
        v.exp_mis = m_illegal(v.f3, v.addr);
        v.exp_err = 0;
        v.exp_be  = 4'hF;
        v.exp_wdata = '0;
        if (v.exp_mis) begin
            mm = '0;
        end else if (v.wr) begin
            v.exp_wdata = m_wdata(v.f3, v.sd);
            v.exp_be    = m_be(v.f3, v.addr);
        end else begin
            mm = m_load(v.f3, v.addr, v.rdata);
        end
        v.exp_mem = mm;
    endtask

    vec_t        vecs[15];
    vec_t        rv;
    logic [31:0] model_mem;
    int          cnt4, vcnt4;
    bit          done4;

    initial begin
        rst = 0; req_read = 0; req_write = 0; funct3 = '0; addr = '0; store_data = '0;
        r4_read = 0; r4_f3 = '0; r4_addr = '0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = '0;
        bus4.req_ready = 0; bus4.rsp_valid = 0; bus4.rsp_rdata = '0;

        //           rd wr f3  addr          sd            rdata         rdy rsp mem           wdata         be     mis err
        vecs[0]  = mk(1, 0, 3'd0 + F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0, 4'hF, 0, 0);
        vecs[1]  = mk(1, 0, F3_LB,  32'h103, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFFFF80, 32'h0, 4'hF, 0, 0);
        vecs[2]  = mk(1, 0, F3_LBU, 32'h103, 32'h0,        32'h80FF_0000, 0, 0, 32'h00000080, 32'h0, 4'hF, 0, 0);
        vecs[3]  = mk(1, 0, F3_LH,  32'h102, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFF80FF, 32'h0, 4'hF, 0, 0);
        vecs[4]  = mk(0, 1, F3_LB,  32'h201, 32'h12345678, 32'h0,         0, 0, 32'hFFFF80FF, 32'h78787878, 4'b0010, 0, 0);
        vecs[5]  = mk(1, 0, F3_LW,  32'h102, 32'h0,        32'h11111111,  0, 0, 32'h0, 32'h0, 4'hF, 1, 0);
        vecs[6]  = mk(0, 1, F3_LH,  32'h301, 32'h5555AAAA, 32'h0,         0, 0, 32'h0, 32'h0, 4'hF, 1, 0);
        vecs[7]  = mk(1, 0, F3_LHU, 32'h102, 32'h0,        32'h80FF_0000, 0, 0, 32'h000080FF, 32'h0, 4'hF, 0, 0);
        vecs[8]  = mk(0, 1, F3_LW,  32'h400, 32'hCAFEF00D, 32'h0,        10, 0, 32'h000080FF, 32'hCAFEF00D, 4'hF, 0, 0);
        vecs[9]  = mk(1, 0, 3'b011, 32'h104, 32'h0,        32'h0,         0, 0, 32'h0, 32'h0, 4'hF, 1, 0);
        vecs[10] = mk(1, 1, F3_LH,  32'h302, 32'h0000ABCD, 32'h0,         0, 0, 32'h0, 32'hABCDABCD, 4'b1100, 0, 0);
        vecs[11] = mk(1, 0, F3_LB,  32'h100, 32'h0,        32'h0000007F,  0, 3, 32'h0000007F, 32'h0, 4'hF, 0, 0);
        vecs[12] = mk(1, 0, F3_LW,  32'h500, 32'h0,        32'h0,       300, 0, 32'h0, 32'h0, 4'hF, 0, 1);
        vecs[13] = mk(0, 1, F3_LB,  32'h203, 32'h000000A5, 32'h0,         1, 0, 32'h0, 32'hA5A5A5A5, 4'b1000, 0, 0);
        vecs[14] = mk(1, 0, F3_LH,  32'h100, 32'h0,        32'h12348001,  2, 1, 32'hFFFF8001, 32'h0, 4'hF, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset req_valid", 32'(bus.req_valid), 32'd0);
        check("reset mem_data", mem_data, 32'h0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1;

        for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("vec%0d", i));

        model_mem = vecs[14].exp_mem;
        for (int i = 0; i < 40; i++) begin
            rv.rd = 1'($urandom_range(0, 1));
            rv.wr = 1'($urandom_range(0, 1));
            if (!rv.rd && !rv.wr) rv.rd = 1;
            rv.f3 = 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            rv.sd = $urandom;
            rv.rdata = $urandom;
            rv.rdy_dly = $urandom_range(0, 3);
            rv.rsp_dly = $urandom_range(0, 3);
            model_fill(rv, model_mem);
            apply(rv, $sformatf("rand%0d", i));
        end

        // Reset while a load waits for its response.
        req_read = 1; funct3 = F3_LW; addr = 32'h600; bus.req_ready = 1; bus.rsp_valid = 0;
        @(negedge clk); check("rstseq idle stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check("rstseq req_valid", 32'(bus.req_valid), 32'd1);
        @(posedge clk); #1;
        bus.req_ready = 0; rst = 0;
        @(negedge clk); check("rstseq wait stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstseq after reset req_valid", 32'(bus.req_valid), 32'd0);
        check("rstseq after reset stall", 32'(stall), 32'd1);
        check("rstseq after reset mem_data", mem_data, 32'h0);
        @(posedge clk); #1;
        rst = 1; req_read = 0; bus.rsp_valid = 1; bus.rsp_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray rsp mem_data", mem_data, 32'h0);
            check("stray rsp stall", 32'(stall), 32'd0);
            check("stray rsp req_valid", 32'(bus.req_valid), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_valid = 0;

        // TIMEOUT=4 instance: memory never accepts.
        r4_read = 1; r4_f3 = F3_LW; r4_addr = 32'h10;
        cnt4 = 0; vcnt4 = 0; done4 = 0;
        for (int i = 0; i < 20 && !done4; i++) begin
            @(negedge clk);
            if (stall4) begin
                cnt4++;
                if (bus4.req_valid) vcnt4++;
            end else begin
                done4 = 1;
                check("timeout bus_err", 32'(err4), 32'd1);
                check("timeout mem_data", mem4, 32'h0);
                check("timeout req_valid dropped", 32'(bus4.req_valid), 32'd0);
                check("timeout misaligned", 32'(mis4), 32'd0);
            end
            @(posedge clk); #1;
        end
        r4_read = 0;
        check("timeout completes", 32'(done4), 32'd1);
        check("timeout stall cycles", cnt4, 5);
        check("timeout req_valid cycles", vcnt4, 4);
        @(negedge clk);
        check("timeout bus_err pulse ends", 32'(err4), 32'd0);
        check("timeout idle stall", 32'(stall4), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
